// File: rtl/fetch_unit_nw.sv
// fetch_unit_nw
//   N-wide instruction fetch unit. Issues group-aligned requests to
//   instruction memory (at most one outstanding), buffers the returned
//   instructions with their PCs in a circular fetch queue and hands up to
//   FETCH_WIDTH in-order instructions per cycle to decode. Supports jump
//   redirects with queue flush and discard of a stale in-flight response.
//
// Optional feature:
//   FETCH_PREDECODE_EN - when defined, enqueued lanes are predecoded and the
//   first JAL in a returned group redirects fetch (lanes after it dropped).
//
// Ports:
//   clk              clock, rising edge
//   rst              asynchronous active-low reset
//   start_addr       boot PC, sampled in BOOT
//   isJump           single-cycle redirect request
//   jump_address     redirect target (bits [1:0] ignored)
//   imem_req_valid   memory request valid
//   imem_req_ready   memory accepts request
//   imem_req_addr    group-aligned request address
//   imem_resp_valid  in-order response valid (latency >= 1)
//   imem_resp_data   FETCH_WIDTH words, lane i = word at req_addr + 4*i
//   instruction      lanes to decode
//   instruction_addr per-lane PC
//   valid            per-lane valid, contiguous from lane 0
//   dec_ready        decode consumes all valid lanes this cycle
//   dbg_state        current FSM state (BOOT=0, FETCH=1, WAIT=2, DRAIN=3)
//   dbg_count        current fetch queue occupancy
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; valid never depends on ready, and the request address is held
// stable while valid is high.

module fetch_unit_nw #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int FETCH_WIDTH = 2,
    parameter int QUEUE_DEPTH = 8
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [ADDR_WIDTH-1:0]             start_addr,
    input  logic                              isJump,
    input  logic [ADDR_WIDTH-1:0]             jump_address,
    output logic                              imem_req_valid,
    input  logic                              imem_req_ready,
    output logic [ADDR_WIDTH-1:0]             imem_req_addr,
    input  logic                              imem_resp_valid,
    input  logic [FETCH_WIDTH*DATA_WIDTH-1:0] imem_resp_data,
    output logic [FETCH_WIDTH*DATA_WIDTH-1:0] instruction,
    output logic [FETCH_WIDTH*ADDR_WIDTH-1:0] instruction_addr,
    output logic [FETCH_WIDTH-1:0]            valid,
    input  logic                              dec_ready,
    output logic [1:0]                        dbg_state,
    output logic [$clog2(QUEUE_DEPTH):0]      dbg_count
);

    localparam int OFF_W  = $clog2(FETCH_WIDTH * 4);
    localparam int LANE_W = (FETCH_WIDTH > 1) ? $clog2(FETCH_WIDTH) : 1;
    localparam int PTR_W  = $clog2(QUEUE_DEPTH);
    localparam int CNT_W  = PTR_W + 1;

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_FETCH = 2'd1,
        S_WAIT  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t                 state, state_next;
    logic [ADDR_WIDTH-1:0]  pc, pc_next;
    logic [ADDR_WIDTH-1:0]  req_base;   // aligned address of the outstanding group
    logic [LANE_W-1:0]      req_off;    // first lane of that group we actually want
    logic [PTR_W-1:0]       head, tail;
    logic [CNT_W-1:0]       count;

    logic [DATA_WIDTH-1:0]  mem_data [QUEUE_DEPTH];
    logic [ADDR_WIDTH-1:0]  mem_addr [QUEUE_DEPTH];

    logic [ADDR_WIDTH-1:0]  aligned_pc;
    logic [LANE_W-1:0]      pc_lane;
    logic [CNT_W-1:0]       free_slots;
    logic                   req_fire;
    logic                   jump_act;
    logic                   enq_en;
    logic [CNT_W-1:0]       base_n;
    logic [CNT_W-1:0]       enq_n;
    logic [CNT_W-1:0]       enq_amt;
    logic [CNT_W-1:0]       pop_n;
    logic [DATA_WIDTH-1:0]  enq_data [FETCH_WIDTH];
    logic [ADDR_WIDTH-1:0]  enq_addr [FETCH_WIDTH];

`ifdef FETCH_PREDECODE_EN
    logic                   jal_hit;
    logic [ADDR_WIDTH-1:0]  jal_target;

    // Sign-extended J-type immediate: imm[20|10:1|11|19:12] = w[31|30:21|20|19:12].
    function automatic logic [ADDR_WIDTH-1:0] jal_offset(input logic [DATA_WIDTH-1:0] w);
        logic signed [20:0] imm;
        imm = {w[31], w[19:12], w[20], w[30:21], 1'b0};
        return ADDR_WIDTH'(imm);
    endfunction
`endif

    // ------------------------------------------------------------------
    // Address helpers and handshake qualifiers
    // ------------------------------------------------------------------
    assign aligned_pc = {pc[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
    assign pc_lane    = LANE_W'(pc[OFF_W-1:0] >> 2);
    assign free_slots = CNT_W'(QUEUE_DEPTH) - count;
    assign req_fire   = imem_req_valid && imem_req_ready;
    // BOOT has no PC yet, so a redirect there is meaningless and ignored.
    assign jump_act   = isJump && (state != S_BOOT);
    assign enq_en     = (state == S_WAIT) && imem_resp_valid && !jump_act;
    assign enq_amt    = enq_en ? enq_n : '0;
    assign pop_n      = (dec_ready && !jump_act)
                        ? ((count > CNT_W'(FETCH_WIDTH)) ? CNT_W'(FETCH_WIDTH) : count)
                        : '0;

    assign imem_req_addr = aligned_pc;
    assign dbg_state     = state;
    assign dbg_count     = count;

    // ------------------------------------------------------------------
    // Response compaction: slot j of the enqueue bundle takes lane
    // req_off + j, so kept lanes land contiguously at the queue tail.
    // ------------------------------------------------------------------
    always_comb begin
        base_n = CNT_W'(FETCH_WIDTH) - CNT_W'(req_off);
        enq_n  = base_n;
        for (int j = 0; j < FETCH_WIDTH; j++) begin
            enq_data[j] = '0;
            enq_addr[j] = '0;
            for (int i = 0; i < FETCH_WIDTH; i++) begin
                if (int'(req_off) + j == i) begin
                    enq_data[j] = imem_resp_data[i*DATA_WIDTH +: DATA_WIDTH];
                    enq_addr[j] = req_base + ADDR_WIDTH'(4 * i);
                end
            end
        end
`ifdef FETCH_PREDECODE_EN
        jal_hit    = 1'b0;
        jal_target = '0;
        for (int j = 0; j < FETCH_WIDTH; j++) begin
            if ((CNT_W'(j) < base_n) && !jal_hit && (enq_data[j][6:0] == 7'b1101111)) begin
                jal_hit    = 1'b1;
                jal_target = enq_addr[j] + jal_offset(enq_data[j]);
                // Keep the JAL itself, drop everything after it.
                enq_n      = CNT_W'(j + 1);
            end
        end
`endif
    end

    // ------------------------------------------------------------------
    // FSM next-state, PC and request valid
    // ------------------------------------------------------------------
    always_comb begin
        state_next     = state;
        pc_next        = pc;
        imem_req_valid = 1'b0;

        case (state)
            S_BOOT: begin
                pc_next    = start_addr;
                state_next = S_FETCH;
            end
            S_FETCH: begin
                // Only one group in flight, so requiring room for a full group
                // here reserves space for it until it returns.
                imem_req_valid = (free_slots >= CNT_W'(FETCH_WIDTH));
                if (req_fire) begin
                    pc_next    = aligned_pc + ADDR_WIDTH'(FETCH_WIDTH * 4);
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_resp_valid) begin
                    state_next = S_FETCH;
`ifdef FETCH_PREDECODE_EN
                    if (jal_hit) begin
                        pc_next = jal_target;
                    end
`endif
                end
            end
            S_DRAIN: begin
                if (imem_resp_valid) begin
                    state_next = S_FETCH;
                end
            end
            default: begin
                state_next = S_BOOT;
            end
        endcase

        if (jump_act) begin
            pc_next = jump_address & ~ADDR_WIDTH'(3);
            // A request accepted this very cycle, or one still in flight,
            // will produce a response that must be thrown away.
            if (((state == S_FETCH) && req_fire) ||
                (((state == S_WAIT) || (state == S_DRAIN)) && !imem_resp_valid)) begin
                state_next = S_DRAIN;
            end else begin
                state_next = S_FETCH;
            end
        end
    end

    // ------------------------------------------------------------------
    // State, PC and queue pointers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_BOOT;
            pc       <= '0;
            req_base <= '0;
            req_off  <= '0;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
        end else begin
            state <= state_next;
            pc    <= pc_next;
            if (req_fire) begin
                req_base <= aligned_pc;
                req_off  <= pc_lane;
            end
            if (jump_act) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                head  <= head + PTR_W'(pop_n);
                tail  <= tail + PTR_W'(enq_amt);
                count <= count + enq_amt - pop_n;
            end
        end
    end

    // Queue storage needs no reset: every read is masked by count.
    always_ff @(posedge clk) begin
        if (enq_en) begin
            for (int j = 0; j < FETCH_WIDTH; j++) begin
                if (CNT_W'(j) < enq_n) begin
                    mem_data[tail + PTR_W'(j)] <= enq_data[j];
                    mem_addr[tail + PTR_W'(j)] <= enq_addr[j];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Decode handoff, combinational from head
    // ------------------------------------------------------------------
    always_comb begin
        valid            = '0;
        instruction      = '0;
        instruction_addr = '0;
        for (int k = 0; k < FETCH_WIDTH; k++) begin
            valid[k] = (count > CNT_W'(k));
            if (valid[k]) begin
                instruction[k*DATA_WIDTH +: DATA_WIDTH]      = mem_data[head + PTR_W'(k)];
                instruction_addr[k*ADDR_WIDTH +: ADDR_WIDTH] = mem_addr[head + PTR_W'(k)];
            end
        end
    end

endmodule
